player_projectile: RTL and testbench

PLAYER_PROJECTILE -- requirements
Module: player_projectile

---
 rtl/player_projectile.sv | 122 ++++++++++++
 tb/tb_player_projectile.sv | 137 +++++++++++++
 2 files changed

// File: rtl/player_projectile.sv
// rtl/player_projectile.sv - single player projectile: launch on fire edge, fly up per frame, cooldown before re-fire.
module player_projectile #(
  parameter int PROJECTILE_WIDTH  = 16,
  parameter int PROJECTILE_HEIGHT = 32,
  parameter int PLAYER_WIDTH      = 64,
  parameter int PLAYER_YPOS       = 700,
  parameter int SCREEN_WIDTH      = 1024,
  parameter int SPEED             = 8,
  parameter int COOLDOWN_FRAMES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [11:0] player_xpos,
  input  logic        bullet_hit,
  output logic [11:0] projectile_xpos,
  output logic [11:0] projectile_ypos,
  output logic        bullet_active,
  output logic        shot_fired
);

  localparam logic [12:0] X_OFFSET   = 13'((PLAYER_WIDTH - PROJECTILE_WIDTH) / 2);
  localparam logic [12:0] X_MAX      = 13'(SCREEN_WIDTH - PROJECTILE_WIDTH);
  localparam logic [11:0] Y_LAUNCH   = 12'(PLAYER_YPOS - PROJECTILE_HEIGHT);
  localparam logic [11:0] SPEED_L    = 12'(SPEED);
  localparam logic [7:0]  COOLDOWN_L = 8'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        fire_prev_q;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        active_q;
  logic        shot_q, shot_d;

  logic        fire_rise;
  logic [12:0] x_sum;
  logic [11:0] x_launch;

  assign fire_rise = fire & ~fire_prev_q;
  assign x_sum     = {1'b0, player_xpos} + X_OFFSET;
  // Sum is kept 13 bits wide so a right-edge player cannot wrap before the clamp.
  assign x_launch  = (x_sum > X_MAX) ? X_MAX[11:0] : x_sum[11:0];

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    cnt_d   = cnt_q;
    shot_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire_rise) begin
          state_d = FLYING;
          xpos_d  = x_launch;
          ypos_d  = Y_LAUNCH;
          shot_d  = 1'b1;
        end
      end
      FLYING: begin
        if (bullet_hit) begin
          state_d = COOLDOWN;
          cnt_d   = COOLDOWN_L;
        end else if (frame_tick) begin
          if (ypos_q >= SPEED_L) begin
            ypos_d = ypos_q - SPEED_L;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = COOLDOWN_L;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fire_prev_q <= 1'b1;
      xpos_q      <= 12'd0;
      ypos_q      <= 12'd0;
      cnt_q       <= 8'd0;
      active_q    <= 1'b0;
      shot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fire_prev_q <= fire;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      cnt_q       <= cnt_d;
      active_q    <= (state_d == FLYING);
      shot_q      <= shot_d;
    end
  end

  assign projectile_xpos = xpos_q;
  assign projectile_ypos = ypos_q;
  assign bullet_active   = active_q;
  assign shot_fired      = shot_q;

endmodule

// File: tb/tb_player_projectile.sv
// tb/tb_player_projectile.sv - directed self-checking bench for player_projectile.
module tb_player_projectile;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        fire;
  logic [11:0] player_xpos;
  logic        bullet_hit;
  logic [11:0] projectile_xpos;
  logic [11:0] projectile_ypos;
  logic        bullet_active;
  logic        shot_fired;

  int checks = 0;
  int errors = 0;
  int shot_count = 0;

  player_projectile dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .fire            (fire),
    .player_xpos     (player_xpos),
    .bullet_hit      (bullet_hit),
    .projectile_xpos (projectile_xpos),
    .projectile_ypos (projectile_ypos),
    .bullet_active   (bullet_active),
    .shot_fired      (shot_fired)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && shot_fired) shot_count++;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; fire = 1'b1; player_xpos = 12'd100; bullet_hit = 1'b0;
    @(negedge clk);
    step();
    chk("rst_x", projectile_xpos, 0);
    chk("rst_y", projectile_ypos, 0);
    chk("rst_active", bullet_active, 0);
    chk("rst_shot", shot_fired, 0);

    // fire held through reset release must not launch
    rst = 1'b0;
    step(); step();
    chk("held_rst_active", bullet_active, 0);
    chk("held_rst_shot", shot_fired, 0);

    fire = 1'b0; step();
    fire = 1'b1; step();
    chk("launch_active", bullet_active, 1);
    chk("launch_shot", shot_fired, 1);
    chk("launch_x", projectile_xpos, 124);
    chk("launch_y", projectile_ypos, 668);
    step();
    chk("shot_one_cycle", shot_fired, 0);

    player_xpos = 12'd500;
    tick(); tick(); tick();
    chk("y_after3", projectile_ypos, 644);
    chk("x_hold", projectile_xpos, 124);

    for (int i = 0; i < 80; i++) tick();
    chk("y_after83", projectile_ypos, 4);
    chk("active_after83", bullet_active, 1);
    tick();
    chk("top_retire_active", bullet_active, 0);
    chk("top_retire_y", projectile_ypos, 4);

    bullet_hit = 1'b1; step(); bullet_hit = 1'b0;
    chk("hit_in_cooldown", bullet_active, 0);
    tick(); tick();
    fire = 1'b0; step();
    fire = 1'b1; step();
    chk("edge_in_cooldown", bullet_active, 0);
    tick(); tick();
    step(); step();
    chk("no_autofire", bullet_active, 0);
    chk("shot_count", shot_count, 1);

    fire = 1'b0; step();
    fire = 1'b1; step();
    chk("relaunch_active", bullet_active, 1);
    chk("relaunch_x", projectile_xpos, 524);
    for (int i = 0; i < 21; i++) tick();
    chk("y_500", projectile_ypos, 500);
    bullet_hit = 1'b1; frame_tick = 1'b1; step();
    bullet_hit = 1'b0; frame_tick = 1'b0;
    chk("hit_tick_active", bullet_active, 0);
    chk("hit_tick_y", projectile_ypos, 500);

    tick(); tick(); tick(); tick();
    bullet_hit = 1'b1; step(); bullet_hit = 1'b0;
    step();
    chk("hit_in_idle", bullet_active, 0);
    chk("hold_y_idle", projectile_ypos, 500);

    player_xpos = 12'd1020;
    fire = 1'b0; step();
    fire = 1'b1; step();
    chk("clamp_active", bullet_active, 1);
    chk("clamp_x", projectile_xpos, 1008);
    chk("clamp_y", projectile_ypos, 668);

    tick();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_x", projectile_xpos, 0);
    chk("midrst_y", projectile_ypos, 0);
    chk("midrst_active", bullet_active, 0);
    chk("midrst_shot", shot_fired, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
